// File: rtl/ring_sequencer_pkg.sv
// ring_pkg: shared constants and helpers for the ring sequencer.
package ring_pkg;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Index width helper; returns at least 1 so 1-bit indices stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    if (r == 0) r = 1;
    return r;
  endfunction
endpackage

// File: rtl/ring_sequencer_if.sv
// Control/status bundle for ring_sequencer. Port names keep the
// phase-suffixed (_s1) naming of the surrounding control path.
interface ring_sequencer_if
  import ring_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int MAX_SHIFT = 2
);
  localparam int IW = clog2(WIDTH);

  logic                 Enable_s1;
  logic                 Dir_s1;
  logic                 Load_s1;
  logic [IW-1:0]        LoadPos_s1;
  logic [MAX_SHIFT:0]   ShiftSel_s1;
  logic [WIDTH-1:0]     State_s1;
  logic [IW-1:0]        Pos_s1;
  logic                 Wrap_s1;
  logic [WIDTH-1:0]     Shifted_s1;

  modport master (
    output Enable_s1, Dir_s1, Load_s1, LoadPos_s1, ShiftSel_s1,
    input  State_s1, Pos_s1, Wrap_s1, Shifted_s1
  );

  modport slave (
    input  Enable_s1, Dir_s1, Load_s1, LoadPos_s1, ShiftSel_s1,
    output State_s1, Pos_s1, Wrap_s1, Shifted_s1
  );
endinterface

// File: rtl/ring_sequencer_wrapshift.sv
// ring_wrapshift: combinational rotate-right by a one-hot distance select.
// A zero or multi-hot select passes the input through unshifted.
module ring_wrapshift #(
  parameter int WIDTH     = 9,
  parameter int MAX_SHIFT = 2
) (
  input  logic [WIDTH-1:0]   din_i,
  input  logic [MAX_SHIFT:0] sel_i,
  output logic [WIDTH-1:0]   dout_o
);
  // Pick the rotation for the single set select bit, else pass through.
  always_comb begin
    dout_o = din_i;
    if ($onehot(sel_i)) begin
      for (int k = 0; k <= MAX_SHIFT; k++) begin
        if (sel_i[k]) dout_o = (din_i >> k) | (din_i << (WIDTH - k));
      end
    end
  end
endmodule

// File: rtl/ring_sequencer.sv
// ring_sequencer: one-hot ring counter with load, direction, terminal-count
// pulse and a registered wrap-shifter output stage.
// Optional feature macro: RING_SEQUENCER_SHIFT_EN (shifter + output register).
module ring_sequencer
  import ring_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int INIT_POS  = 0,
  parameter int MAX_SHIFT = 2
) (
  input  logic          Phi1,
  input  logic          Reset_b,
  ring_sequencer_if.slave rs
);
  localparam int             IW       = clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_OH = ONE << INIT_POS;
  localparam logic [IW-1:0]  INIT_IDX = IW'(INIT_POS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [IW-1:0]    pos_q, pos_d;
  logic             wrap_q, wrap_d;

  // Next ring state: load beats step beats hold; wrap only on a crossing step.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    if (rs.Load_s1) begin
      if (32'(rs.LoadPos_s1) >= WIDTH) begin
        state_d = INIT_OH;
        pos_d   = INIT_IDX;
      end else begin
        state_d = ONE << rs.LoadPos_s1;
        pos_d   = rs.LoadPos_s1;
      end
    end else if (rs.Enable_s1) begin
      if (rs.Dir_s1 == DIR_UP) begin
        state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        pos_d   = (pos_q == LAST_IDX) ? '0 : pos_q + IW'(1);
        wrap_d  = state_q[WIDTH-1];
      end else begin
        state_d = {state_q[0], state_q[WIDTH-1:1]};
        pos_d   = (pos_q == '0) ? LAST_IDX : pos_q - IW'(1);
        wrap_d  = state_q[0];
      end
    end
  end

  // Ring, position and terminal-count registers.
  always_ff @(posedge Phi1 or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= INIT_OH;
      pos_q   <= INIT_IDX;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
    end
  end

  assign rs.State_s1 = state_q;
  assign rs.Pos_s1   = pos_q;
  assign rs.Wrap_s1  = wrap_q;

`ifdef RING_SEQUENCER_SHIFT_EN
  logic [WIDTH-1:0] shifted_d, shifted_q;

  // Shift the next state so the registered output lines up with State_s1.
  ring_wrapshift #(.WIDTH(WIDTH), .MAX_SHIFT(MAX_SHIFT)) u_wrapshift (
    .din_i  (state_d),
    .sel_i  (rs.ShiftSel_s1),
    .dout_o (shifted_d)
  );

  // Output register for the shifted view.
  always_ff @(posedge Phi1 or negedge Reset_b) begin
    if (!Reset_b) shifted_q <= INIT_OH;
    else          shifted_q <= shifted_d;
  end

  assign rs.Shifted_s1 = shifted_q;
`else
  // Shifter absent: select is ignored and the output mirrors the ring.
  logic unused_shiftsel;
  assign unused_shiftsel = ^rs.ShiftSel_s1;
  assign rs.Shifted_s1   = state_q;
`endif
endmodule

// File: tb/tb_ring_sequencer.sv
// Bench for ring_sequencer: directed vector table, mid-cycle reset sequence,
// and random traffic against a position-based reference model.
module tb_ring_sequencer;
  import ring_pkg::*;

  localparam int W  = 9;
  localparam int IP = 8;
  localparam int MS = 2;
  localparam int IW = clog2(W);

  typedef struct {
    bit          load;
    int          lp;
    bit          en;
    bit          dir;
    logic [MS:0] sel;
    int          epos;
    bit          ewrap;
  } vec_t;

  logic Phi1, Reset_b;
  int   checks, errors;
  vec_t tbl[$];

  // model state: index of the hot bit, pending wrap, hot bit of shifted view
  int mpos, msh;
  bit mwrap;

  ring_sequencer_if #(.WIDTH(W), .MAX_SHIFT(MS)) rif ();

  ring_sequencer #(.WIDTH(W), .INIT_POS(IP), .MAX_SHIFT(MS)) dut (
    .Phi1    (Phi1),
    .Reset_b (Reset_b),
    .rs      (rif.slave)
  );

  initial begin
    Phi1 = 1'b0;
    forever #5 Phi1 = ~Phi1;
  end

  // Where the hot bit of Shifted lands for a ring position and select.
  function automatic int exp_shift(input int p, input logic [MS:0] sel);
`ifdef RING_SEQUENCER_SHIFT_EN
    int cnt, k;
    cnt = 0; k = 0;
    for (int i = 0; i <= MS; i++) if (sel[i]) begin cnt++; k = i; end
    if (cnt == 1) return (p - k + W) % W;
    return p;
`else
    return p;
`endif
  endfunction

  function automatic logic [W-1:0] oh(input int p);
    logic [W-1:0] one;
    one = 1;
    return one << p;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int epos, input bit ewrap, input int eshp);
    cmp({nm, ".state"},   64'(rif.State_s1),   64'(oh(epos)));
    cmp({nm, ".pos"},     64'(rif.Pos_s1),     64'(epos));
    cmp({nm, ".wrap"},    64'(rif.Wrap_s1),    64'(ewrap));
    cmp({nm, ".shifted"}, 64'(rif.Shifted_s1), 64'(oh(eshp)));
  endtask

  task automatic drive(input bit load, input int lp, input bit en, input bit dir, input logic [MS:0] sel);
    rif.Load_s1     = load;
    rif.LoadPos_s1  = IW'(lp);
    rif.Enable_s1   = en;
    rif.Dir_s1      = dir;
    rif.ShiftSel_s1 = sel;
  endtask

  // Reference step: positions move modulo W; crossing the ends flags wrap.
  task automatic model_edge(input bit load, input int lp, input bit en, input bit dir, input logic [MS:0] sel);
    if (load) begin
      mpos  = (lp < W) ? lp : IP;
      mwrap = 1'b0;
    end else if (en) begin
      if (dir == DIR_UP) begin
        mwrap = (mpos == W - 1);
        mpos  = (mpos + 1) % W;
      end else begin
        mwrap = (mpos == 0);
        mpos  = (mpos + W - 1) % W;
      end
    end else begin
      mwrap = 1'b0;
    end
    msh = exp_shift(mpos, sel);
  endtask

  function automatic vec_t mk(input bit load, input int lp, input bit en, input bit dir,
                              input logic [MS:0] sel, input int epos, input bit ewrap);
    vec_t v;
    v.load = load; v.lp = lp; v.en = en; v.dir = dir; v.sel = sel;
    v.epos = epos; v.ewrap = ewrap;
    return v;
  endfunction

  initial begin
    checks = 0; errors = 0;
    Reset_b = 1'b0;
    drive(0, 0, 0, 0, '0);

    // directed table, starting from the reset position IP
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0));
    for (int i = 1; i < W; i++) tbl.push_back(mk(0, 0, 1, 0, 3'b000, i, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3'b000, 0, 1));  // full lap back to bit 0
    tbl.push_back(mk(0, 0, 1, 1, 3'b000, 8, 1));  // down-crossing
    tbl.push_back(mk(0, 0, 1, 0, 3'b000, 0, 1));  // reversed, up-crossing
    tbl.push_back(mk(1, 5, 1, 1, 3'b000, 5, 0));  // load beats enable
    tbl.push_back(mk(1, 12, 0, 0, 3'b000, IP, 0)); // out-of-range load
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, IP, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3'b000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0));  // wrap lasts one cycle
    tbl.push_back(mk(1, 8, 1, 0, 3'b000, 8, 0));  // load across boundary: no wrap
    tbl.push_back(mk(1, 0, 0, 0, 3'b010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b100, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b011, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'b001, 8, 1));

    #12;
    check_all("reset", IP, 0, IP);
    Reset_b = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].load, tbl[i].lp, tbl[i].en, tbl[i].dir, tbl[i].sel);
      @(posedge Phi1); #1;
      check_all($sformatf("vec%0d", i), tbl[i].epos, tbl[i].ewrap,
                exp_shift(tbl[i].epos, tbl[i].sel));
    end

    // crossing step leaves a wrap pending, then reset between edges
    drive(0, 0, 1, 0, 3'b000);
    @(posedge Phi1); #1;
    check_all("pre_rst", 0, 1, 0);
    #3 Reset_b = 1'b0;
    #1 check_all("mid_rst", IP, 0, IP);
    #1 Reset_b = 1'b1;
    @(posedge Phi1); #1;
    check_all("post_rst", 0, 1, 0);

    // random traffic against the model
    mpos = 0; mwrap = 1'b1;
    for (int n = 0; n < 400; n++) begin
      bit          ld, en, dir;
      int          lp;
      logic [MS:0] sel;
      ld  = ($urandom_range(0, 7) == 0);
      lp  = $urandom_range(0, (1 << IW) - 1);
      en  = ($urandom_range(0, 3) != 0);
      dir = $urandom_range(0, 1);
      sel = MS'(0) | (MS+1)'($urandom_range(0, (1 << (MS+1)) - 1));
      drive(ld, lp, en, dir, sel);
      model_edge(ld, lp, en, dir, sel);
      @(posedge Phi1); #1;
      check_all($sformatf("rnd%0d", n), mpos, mwrap, msh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ring_sequencer.md
# ring_sequencer

Parametrised one-hot ring counter with an integrated, registered wrap-shifter output stage. It generalises the fixed 3/8/9-stage ring counters and the 0/1/2 wrap-shifter into one block with these parameters: stage count, reset position, rotation direction, parallel load, terminal-count pulse and programmable shift depth. It sits in the control path and drives word-line, pixel-mux and kernel-mux selects; the shifted output feeds the memory write drivers, which do their own qualification.

## Interface
- WIDTH, 9, number of ring stages; legal range 2..64.
- INIT_POS, 0, bit index held after reset; legal range 0..WIDTH-1.
- MAX_SHIFT, 2, largest rotate-right distance of the shifter; legal range 0..WIDTH-1.
- Phi1  in  1  clock; all state updates on the rising edge.
- Reset_b  in  1  asynchronous, active-low reset.
- Enable_s1  in  1  advances the ring by one position per cycle.
- Dir_s1  in  1  direction: 0 moves bit i to i+1 (MSB wraps to bit 0); 1 moves bit i to i-1 (bit 0 wraps to MSB).
- Load_s1  in  1  loads one-hot position LoadPos_s1.
- LoadPos_s1  in  $clog2(WIDTH)  binary index to load.
- ShiftSel_s1  in  MAX_SHIFT+1  one-hot shift select; bit k selects rotate right by k.
- State_s1  out  WIDTH  one-hot ring state.
- Pos_s1  out  $clog2(WIDTH)  binary index of the set bit in State_s1.
- Wrap_s1  out  1  one-cycle terminal-count pulse.
- Shifted_s1  out  WIDTH  State_s1 rotated right by the selected amount.

## Operation
- Reset (Reset_b=0, asynchronous) produces these values:
  - State_s1 = 1<<INIT_POS.
  - Pos_s1 = INIT_POS.
  - Wrap_s1 = 0.
  - Shifted_s1 = 1<<INIT_POS.
- Update priority each cycle: Load_s1 first, then Enable_s1, then hold.
- Load:
  - State becomes 1<<LoadPos_s1 regardless of Enable_s1 and Dir_s1.
  - If LoadPos_s1 ≥ WIDTH, state becomes 1<<INIT_POS instead.
  - A load never produces a Wrap pulse.
- Step: the ring rotates one position in the direction given by Dir_s1. Dir_s1 is sampled every cycle, so reversing it mid-sequence is legal and takes effect on the next step.
- Wrap pulse:
  - Wrap_s1 is set for exactly one cycle after any step that crosses the boundary.
  - With Dir=0, the crossing step moves bit WIDTH-1 to bit 0.
  - With Dir=1, the crossing step moves bit 0 to bit WIDTH-1.
  - Otherwise Wrap_s1 is 0.
- Pos_s1 is registered alongside State_s1 and always equals the index of the set bit in State_s1.
- Shifter:
  - Shifted_s1 = ror(State_s1, k) for ShiftSel_s1 == 1<<k: bits [WIDTH-1:k] move down to [WIDTH-1-k:0], and bits [k-1:0] wrap to the top.
  - If ShiftSel_s1 is zero or has more than one bit set, Shifted_s1 = State_s1 (no shift).
- State_s1 is one-hot by construction; no other state values are reachable.

## Timing
- State_s1, Pos_s1 and Wrap_s1 update 1 cycle after the inputs are sampled.
- Shifted_s1 is registered from the next-state value and the current ShiftSel_s1. It is therefore cycle-aligned with State_s1, with the same 1-cycle latency.
- If Reset_b is asserted mid-sequence, every output returns to its reset value immediately, with no clock required. Any pending Wrap pulse is discarded.
- The first edge after Reset_b deasserts acts on inputs normally.
- Load_s1 and Enable_s1 asserted together: the load wins and no step occurs.

## Configuration
- Macro: RING_SEQUENCER_SHIFT_EN.
- Defined: the shifter sub-module and the Shifted_s1 register are present, as described above.
- Undefined:
  - No shifter logic is built.
  - Shifted_s1 is driven directly from State_s1 and tracks it exactly.
  - ShiftSel_s1 is ignored.
  - The port list is unchanged.

## Structure
- Package ring_pkg holds:
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - The clog2 helper used to derive index widths.
- Sub-module ring_wrapshift: purely combinational rotate-right by the one-hot select (parameters WIDTH, MAX_SHIFT), with the no-shift default for an illegal select. It is instantiated only under RING_SEQUENCER_SHIFT_EN.
- The top level holds the ring register, the position and wrap registers, and the output register.

## Test plan
- Reset, WIDTH=9, INIT_POS=8 -> State=9'b1_0000_0000, Pos=8, Wrap=0, Shifted=State.
- Dir=0, Enable held for 9 cycles from 9'b1 -> State walks bit 0..8 then back to bit 0. Wrap=1 only in the cycle where State returns to 9'b1.
- Dir=1 from bit 0, one step -> State=9'b1_0000_0000, Wrap=1. Toggle Dir to 0 on the next step -> State=9'b1, Wrap=1.
- Load_s1=1, LoadPos=5, Enable=1 together -> State=9'b0_0010_0000, Pos=5, Wrap=0. LoadPos=12 -> State=1<<INIT_POS.
- Shifter, State=9'b0_0000_0001 (MAX_SHIFT=2):
  - ShiftSel=3'b010 -> Shifted=9'b1_0000_0000.
  - ShiftSel=3'b100 -> Shifted=9'b0_1000_0000.
  - ShiftSel=3'b011 -> Shifted=9'b0_0000_0001.
  - With the macro undefined, Shifted always equals State.
- Reset_b pulsed low mid-sequence, between clock edges -> outputs return to reset values immediately. A step on the next edge proceeds from INIT_POS.
